seq_gen_1011: RTL and testbench

Serial frame transmitter that produces the bit stream consumed by the 1011 sequence detector. Each accepted parallel word is sent as a 4-bit sync header `1011` followed by the payload, MSB first, one bit per clock. Zero-bit stuffing guarantees that `1011` never appears inside the payload or across frame boundaries. A downstream 1011 detector therefore fires exactly once per frame, on the last header bit.

---
 rtl/seq_gen_1011_if.sv | 33 +++
 rtl/seq_gen_1011.sv | 172 +++++++++++++++++
 tb/tb_seq_gen_1011.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_1011_if.sv
// Handshake and serial-output bundle for the 1011 frame transmitter.
// The master side supplies payload words; the slave side is the transmitter.
interface seq_gen_1011_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_bit;
    logic              tx_en;
    logic              busy;
    logic              frame_done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx_bit,
        input  tx_en,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx_bit,
        output tx_en,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/seq_gen_1011.sv
// Serial frame transmitter: each accepted word goes out as the sync header
// 1011 followed by the payload MSB first. A zero is stuffed in front of any
// payload 1 that would otherwise complete 1011, so a downstream 1011 detector
// fires exactly once per frame, on the last header bit.
// All outputs are registered: the state register names what is on tx_bit
// in the current cycle, and the next-state logic computes next cycle's bit.
module seq_gen_1011 #(
    parameter int DATA_W = 8
) (
    input logic           clk,
    input logic           reset,
    seq_gen_1011_if.slave bus
);
    localparam int         CNT_W   = $clog2(DATA_W + 1);
    localparam logic [3:0] HDR_PAT = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_STUFF = 2'd3
    } state_t;

    // Registered state and outputs
    state_t            state_r;
    logic [1:0]        hdr_cnt_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] shreg_r;
    logic [2:0]        hist_r;
    logic              tx_bit_r;
    logic              tx_en_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              frame_done_r;

    // Next-state values
    state_t            state_s;
    logic [1:0]        hdr_cnt_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [DATA_W-1:0] shreg_s;
    logic [2:0]        hist_s;
    logic              tx_bit_s;
    logic              tx_en_s;
    logic              in_ready_s;
    logic              busy_s;
    logic              frame_done_s;

    // Candidate values for "emit the next payload slot" (payload bit or stuff)
    logic              pending_s;
    logic              stuff_req_s;
    logic              last_s;
    state_t            emit_state_s;
    logic              emit_bit_s;
    logic [DATA_W-1:0] emit_shreg_s;
    logic [CNT_W-1:0]  emit_cnt_s;
    logic              emit_done_s;

    // Decide whether the next payload slot is a stuffed zero or the real bit.
    // A stuffed zero never consumes a payload bit nor touches the bit counter.
    always_comb begin
        pending_s    = shreg_r[DATA_W-1];
        stuff_req_s  = (hist_r == 3'b101) && pending_s;
        last_s       = (cnt_r == CNT_W'(1));
        emit_state_s = stuff_req_s ? ST_STUFF : ST_DATA;
        emit_bit_s   = stuff_req_s ? 1'b0 : pending_s;
        emit_shreg_s = stuff_req_s ? shreg_r : (shreg_r << 1);
        emit_cnt_s   = stuff_req_s ? cnt_r : (cnt_r - CNT_W'(1));
        emit_done_s  = stuff_req_s ? 1'b0 : last_s;
    end

    // Next-state and next-output logic of the frame FSM.
    always_comb begin
        state_s      = state_r;
        hdr_cnt_s    = hdr_cnt_r;
        cnt_s        = cnt_r;
        shreg_s      = shreg_r;
        tx_bit_s     = 1'b0;
        tx_en_s      = 1'b0;
        in_ready_s   = 1'b0;
        frame_done_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    state_s   = ST_HDR;
                    hdr_cnt_s = 2'd0;
                    cnt_s     = CNT_W'(DATA_W);
                    shreg_s   = bus.in_data;
                    tx_bit_s  = HDR_PAT[3];
                    tx_en_s   = 1'b1;
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            ST_HDR: begin
                if (hdr_cnt_r != 2'd3) begin
                    hdr_cnt_s = hdr_cnt_r + 2'd1;
                    tx_bit_s  = HDR_PAT[2'd2 - hdr_cnt_r];
                    tx_en_s   = 1'b1;
                end else begin
                    state_s      = emit_state_s;
                    shreg_s      = emit_shreg_s;
                    cnt_s        = emit_cnt_s;
                    tx_bit_s     = emit_bit_s;
                    tx_en_s      = 1'b1;
                    frame_done_s = emit_done_s;
                end
            end
            ST_DATA: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    // Last payload bit already driven: one mandatory idle gap.
                    state_s    = ST_IDLE;
                    in_ready_s = 1'b1;
                end else begin
                    state_s      = emit_state_s;
                    shreg_s      = emit_shreg_s;
                    cnt_s        = emit_cnt_s;
                    tx_bit_s     = emit_bit_s;
                    tx_en_s      = 1'b1;
                    frame_done_s = emit_done_s;
                end
            end
            ST_STUFF: begin
                state_s      = emit_state_s;
                shreg_s      = emit_shreg_s;
                cnt_s        = emit_cnt_s;
                tx_bit_s     = emit_bit_s;
                tx_en_s      = 1'b1;
                frame_done_s = emit_done_s;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        hist_s = tx_en_s ? {hist_r[1:0], tx_bit_s} : 3'b000;
        busy_s = ~in_ready_s;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            hdr_cnt_r    <= 2'd0;
            cnt_r        <= {CNT_W{1'b0}};
            shreg_r      <= {DATA_W{1'b0}};
            hist_r       <= 3'b000;
            tx_bit_r     <= 1'b0;
            tx_en_r      <= 1'b0;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            hdr_cnt_r    <= hdr_cnt_s;
            cnt_r        <= cnt_s;
            shreg_r      <= shreg_s;
            hist_r       <= hist_s;
            tx_bit_r     <= tx_bit_s;
            tx_en_r      <= tx_en_s;
            in_ready_r   <= in_ready_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.tx_bit     = tx_bit_r;
    assign bus.tx_en      = tx_en_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seq_gen_1011.sv
// Self-checking bench for seq_gen_1011 (DATA_W = 8): table-driven frames,
// hand-written back-to-back and mid-frame reset sequences, and a random soak
// against a queue-based frame model plus an independent 1011 detector.
module tb_seq_gen_1011;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_gen_1011_if #(.DATA_W(8)) bus ();

    seq_gen_1011 #(.DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference 1011 detector on the serial line; also tracks frame position.
    logic [2:0] det_win  = 3'b000;
    int         hits     = 0;
    int         last_pos = -1;
    int         fpos     = 0;

    // Sample the bit of the cycle that just ended (pre-NBA value at posedge).
    always @(posedge clk) begin
        det_win <= {det_win[1:0], bus.tx_bit};
        if ({det_win, bus.tx_bit} == 4'b1011) begin
            hits     <= hits + 1;
            last_pos <= fpos;
        end
        fpos <= (bus.tx_en === 1'b1) ? fpos + 1 : 0;
    end

    typedef struct {
        logic [7:0]  data;
        logic [31:0] frame;
        int          len;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Frame built from the stuffing rule on the whole emitted stream.
    function automatic void model(input logic [7:0] d, output logic [31:0] bits, output int len);
        bit q[$];
        q.push_back(1'b1);
        q.push_back(1'b0);
        q.push_back(1'b1);
        q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) begin
            int n = q.size();
            if (q[n-3] && !q[n-2] && q[n-1] && d[i]) q.push_back(1'b0);
            q.push_back(d[i]);
        end
        bits = 32'd0;
        foreach (q[k]) bits = {bits[30:0], q[k]};
        len = q.size();
    endfunction

    // Offer one word; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input bit hold, input logic [7:0] next_d);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready_wait", 32'(guard < 50), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = hold;
        bus.in_data  = hold ? next_d : 8'($urandom);
    endtask

    // Collect one frame from the line and check it end to end.
    task automatic capture(input string name, input logic [31:0] exp_bits, input int exp_len,
                           input int exp_waits, input bit drop_valid);
        int          waits = 0;
        int          len = 0;
        int          fd_pos = -1;
        int          fd_cnt = 0;
        int          busy_bad = 0;
        int          h0;
        logic [31:0] bits = 32'd0;
        h0 = hits;
        while (bus.tx_en !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check({name, "_start_wait"}, 32'(waits), 32'(exp_waits));
        if (drop_valid) bus.in_valid = 1'b0;
        while (bus.tx_en === 1'b1 && len < 40) begin
            bits = {bits[30:0], bus.tx_bit};
            if (bus.frame_done === 1'b1) begin
                fd_pos = len;
                fd_cnt++;
            end
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) busy_bad++;
            len++;
            @(negedge clk);
        end
        check({name, "_bits"}, bits, exp_bits);
        check({name, "_len"}, 32'(len), 32'(exp_len));
        check({name, "_done_pos"}, 32'(fd_pos), 32'(exp_len - 1));
        check({name, "_done_cnt"}, 32'(fd_cnt), 32'd1);
        check({name, "_busy"}, 32'(busy_bad), 32'd0);
        check({name, "_idle_outs"}, {28'd0, bus.tx_bit, bus.in_ready, bus.busy, bus.frame_done},
              32'b0100);
        check({name, "_det_hits"}, 32'(hits - h0), 32'd1);
        check({name, "_det_pos"}, 32'(last_pos), 32'd3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] eb;
        int          el;
        int          h0;
        int          fd_seen;
        logic [7:0]  d;

        vecs[0] = '{data: 8'hFF, frame: 32'h0000_0BFF, len: 12};
        vecs[1] = '{data: 8'hAA, frame: 32'h0000_0BAA, len: 12};
        vecs[2] = '{data: 8'hB4, frame: 32'h0000_1754, len: 13};
        vecs[3] = '{data: 8'h2D, frame: 32'h0000_1655, len: 13};
        vecs[4] = '{data: 8'h0B, frame: 32'h0000_1615, len: 13};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;

        // Reset values after two reset cycles
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_tx", {28'd0, bus.tx_en, bus.tx_bit, bus.frame_done, bus.busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", {30'd0, bus.in_ready, bus.busy}, 32'b10);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data, 1'b0, 8'h00);
            capture($sformatf("vec%0d", i), vecs[i].frame, vecs[i].len, 0, 1'b1);
        end

        // Back-to-back with in_valid held: exactly one idle cycle between frames
        h0 = hits;
        send(8'hB4, 1'b1, 8'h0B);
        capture("b2b_a", 32'h0000_1754, 13, 0, 1'b0);
        capture("b2b_b", 32'h0000_1615, 13, 1, 1'b1);
        check("b2b_det_total", 32'(hits - h0), 32'd2);

        // Reset in frame cycle 6 aborts the frame
        fd_seen = 0;
        send(8'hFF, 1'b0, 8'h00);
        for (int c = 1; c < 6; c++) begin
            if (bus.frame_done === 1'b1) fd_seen++;
            @(negedge clk);
        end
        check("mid_cycle6_bit", {30'd0, bus.tx_en, bus.tx_bit}, 32'b11);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_outs",
              {27'd0, bus.tx_en, bus.tx_bit, bus.frame_done, bus.busy, bus.in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        if (bus.frame_done === 1'b1) fd_seen++;
        check("mid_no_done", 32'(fd_seen), 32'd0);
        check("mid_after_idle", {29'd0, bus.in_ready, bus.tx_en, bus.tx_bit}, 32'b100);
        send(8'hAA, 1'b0, 8'h00);
        capture("mid_fresh", 32'h0000_0BAA, 12, 0, 1'b1);

        // Random soak against the frame model
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d = 8'($urandom);
            model(d, eb, el);
            send(d, 1'b0, 8'h00);
            capture($sformatf("soak%0d_%02h", n, d), eb, el, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
